win33_out_trans: RTL and testbench

- Output-transform stage of the Winograd F(2x2,3x3) conv datapath. Sits directly downstream of the elementwise-multiply stage.
- Consumes the 4x4 product tile M (sixteen 32-bit signed values) and computes Y = A^T·M·A, with A^T = [[1,1,1,0],[0,1,-1,-1]].
- Accumulates Y across input channels and emits one 2x2 output tile, scaled to fixed-point.
- Converts from the transform domain back to the spatial domain (the inverse direction of the input/filter transforms).

---
 rtl/win33_out_trans_pkg.sv | 23 ++
 rtl/win33_out_trans_if.sv | 31 +++
 rtl/win33_out_trans_at_1d.sv | 26 ++
 rtl/win33_out_trans.sv | 161 ++++++++++++++++
 tb/tb_win33_out_trans.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/win33_out_trans_pkg.sv
// Shared constants for the Winograd F(2x2,3x3) output-transform stage.
// Holds end_signal levels, element widths and the FSM state encoding.
// Imported by the interface, the A^T helper and the top.
package win33_out_trans_pkg;

  // end_signal levels
  localparam logic FINISH   = 1'b1;
  localparam logic UNFINISH = 1'b0;

  // Width of one element of the product tile M
  localparam int EL_W = 32;

  // Each A^T pass adds at most two bits of headroom (sum of three terms)
  localparam int ROW_W = EL_W + 2;
  localparam int COL_W = EL_W + 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ROW  = 2'b01,
    COL  = 2'b11
  } state_t;

endpackage

// File: rtl/win33_out_trans_if.sv
// Tile-in / result-out bundle of the output-transform stage.
// master: upstream multiply stage plus result consumer; slave: the transform.
// No back-pressure: m_valid is a pulse, results are held until the next one.
interface win33_out_trans_if #(
  parameter int OUT_W = 16
);
  import win33_out_trans_pkg::*;

  logic                 m_valid;
  logic [4*EL_W-1:0]    m_tmp1;
  logic [4*EL_W-1:0]    m_tmp2;
  logic [4*EL_W-1:0]    m_tmp3;
  logic [4*EL_W-1:0]    m_tmp4;
  logic                 acc_first;
  logic                 acc_last;
  logic                 busy;
  logic [4*OUT_W-1:0]   y_tmp;
  logic                 end_signal;
  logic                 drop_err;

  modport master (
    output m_valid, m_tmp1, m_tmp2, m_tmp3, m_tmp4, acc_first, acc_last,
    input  busy, y_tmp, end_signal, drop_err
  );

  modport slave (
    input  m_valid, m_tmp1, m_tmp2, m_tmp3, m_tmp4, acc_first, acc_last,
    output busy, y_tmp, end_signal, drop_err
  );

endinterface

// File: rtl/win33_out_trans_at_1d.sv
// One-dimensional A^T pass: (a+b+c, b-c-d) on four signed inputs.
// Purely combinational, zero latency.
// No handshake; the caller registers the result.
module win_at_1d #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W+1:0] s0,
  output logic signed [W+1:0] s1
);

  logic signed [W+1:0] ax, bx, cx, dx;

  // Sign-extend first so the three-term sums cannot overflow
  assign ax = {{2{a[W-1]}}, a};
  assign bx = {{2{b[W-1]}}, b};
  assign cx = {{2{c[W-1]}}, c};
  assign dx = {{2{d[W-1]}}, d};

  assign s0 = ax + bx + cx;
  assign s1 = bx - cx - dx;

endmodule

// File: rtl/win33_out_trans.sv
// Winograd F(2x2,3x3) output transform Y = A^T*M*A, accumulated over channels.
// Latency: tile sampled at edge N, result/end_signal registered at edge N+2.
// No back-pressure: tiles arriving while busy are dropped and flag drop_err.
// Optional: define WIN_OUT_SAT_EN to saturate instead of wrap on narrowing.
module win33_out_trans
  import win33_out_trans_pkg::*;
#(
  parameter int ACC_W      = 40,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  win33_out_trans_if.slave bus
);

  state_t                  state;
  logic [4*EL_W-1:0]       m_q   [4];
  logic                    first_q;
  logic                    last_q;
  logic signed [ROW_W-1:0] t0_q  [4];
  logic signed [ROW_W-1:0] t1_q  [4];
  logic signed [ROW_W-1:0] t0_c  [4];
  logic signed [ROW_W-1:0] t1_c  [4];
  logic signed [COL_W-1:0] y_c   [4];
  logic signed [ACC_W-1:0] acc_q [4];
  logic signed [ACC_W-1:0] acc_nxt [4];
  logic [4*OUT_W-1:0]      y_q;
  logic                    busy_q;
  logic                    end_q;
  logic                    drop_q;

`ifdef WIN_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  // Shift out the fraction bits (floor), then wrap or clamp to OUT_W
  function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_SHIFT;
`ifdef WIN_OUT_SAT_EN
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
`endif
    return s[OUT_W-1:0];
  endfunction

  // Row pass: one A^T per column j of M (element j sits at the MSB end first)
  for (genvar j = 0; j < 4; j++) begin : g_row
    logic signed [EL_W-1:0] e [4];
    for (genvar r = 0; r < 4; r++) begin : g_el
      assign e[r] = m_q[r][(3-j)*EL_W +: EL_W];
    end
    win_at_1d #(.W(EL_W)) u_row (
      .a  (e[0]),
      .b  (e[1]),
      .c  (e[2]),
      .d  (e[3]),
      .s0 (t0_c[j]),
      .s1 (t1_c[j])
    );
  end

  // Column pass: A^T applied along each registered row of T
  win_at_1d #(.W(ROW_W)) u_col0 (
    .a  (t0_q[0]),
    .b  (t0_q[1]),
    .c  (t0_q[2]),
    .d  (t0_q[3]),
    .s0 (y_c[0]),
    .s1 (y_c[1])
  );

  win_at_1d #(.W(ROW_W)) u_col1 (
    .a  (t1_q[0]),
    .b  (t1_q[1]),
    .c  (t1_q[2]),
    .d  (t1_q[3]),
    .s0 (y_c[2]),
    .s1 (y_c[3])
  );

  // Next accumulator value: restart from zero on the first channel of a sum
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      acc_nxt[k] = '0;
      acc_nxt[k] = (first_q ? '0 : acc_q[k])
                 + {{(ACC_W-COL_W){y_c[k][COL_W-1]}}, y_c[k]};
    end
  end

  // Control FSM plus all datapath registers; outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= UNFINISH;
      drop_q  <= 1'b0;
      y_q     <= '0;
      for (int k = 0; k < 4; k++) begin
        m_q[k]   <= '0;
        t0_q[k]  <= '0;
        t1_q[k]  <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      end_q <= UNFINISH;
      if (bus.m_valid && (state != IDLE)) begin
        drop_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.m_valid) begin
            m_q[0]  <= bus.m_tmp1;
            m_q[1]  <= bus.m_tmp2;
            m_q[2]  <= bus.m_tmp3;
            m_q[3]  <= bus.m_tmp4;
            first_q <= bus.acc_first;
            last_q  <= bus.acc_last;
            busy_q  <= 1'b1;
            state   <= ROW;
          end
        end
        ROW: begin
          for (int k = 0; k < 4; k++) begin
            t0_q[k] <= t0_c[k];
            t1_q[k] <= t1_c[k];
          end
          state <= COL;
        end
        COL: begin
          for (int k = 0; k < 4; k++) begin
            acc_q[k] <= acc_nxt[k];
          end
          if (last_q) begin
            y_q   <= {narrow(acc_nxt[0]), narrow(acc_nxt[1]),
                      narrow(acc_nxt[2]), narrow(acc_nxt[3])};
            end_q <= FINISH;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.y_tmp      = y_q;
  assign bus.end_signal = end_q;
  assign bus.drop_err   = drop_q;

endmodule

// File: tb/tb_win33_out_trans.sv
// Directed bench for win33_out_trans with a scoreboard of expected tiles.
// Expected results come from a direct A^T*M*A matrix model.
// Honours WIN_OUT_SAT_EN in the reference narrowing.
module tb_win33_out_trans;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  win33_out_trans_if #(.OUT_W(16)) bus ();

  win33_out_trans dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic signed [31:0] mm [4][4];
  longint             macc [4];
  logic [63:0]        exp_q [$];
  int                 at_m [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_narrow(input longint a);
    longint s;
    s = a >>> 8;
`ifdef WIN_OUT_SAT_EN
    if (s > 32767)       s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  function automatic longint ref_y(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        s += longint'(at_m[r][i]) * longint'(mm[i][j]) * longint'(at_m[c][j]);
    return s;
  endfunction

  function automatic logic [127:0] pack_row(input int r);
    return {mm[r][0], mm[r][1], mm[r][2], mm[r][3]};
  endfunction

  task automatic set_all(input logic signed [31:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mm[i][j] = v;
  endtask

  // Drive one tile for a cycle; optionally account for it in the model
  task automatic drive_tile(input bit first, input bit last, input bit upd, input string tag);
    bus.m_tmp1    = pack_row(0);
    bus.m_tmp2    = pack_row(1);
    bus.m_tmp3    = pack_row(2);
    bus.m_tmp4    = pack_row(3);
    bus.acc_first = first;
    bus.acc_last  = last;
    bus.m_valid   = 1'b1;
    if (upd) begin
      for (int k = 0; k < 4; k++) begin
        if (first) macc[k] = 0;
        macc[k] += ref_y(k / 2, k % 2);
      end
      if (last)
        exp_q.push_back({ref_narrow(macc[0]), ref_narrow(macc[1]),
                         ref_narrow(macc[2]), ref_narrow(macc[3])});
    end
    @(posedge clk); #1;
    bus.m_valid = 1'b0;
    chk({tag, "_busy0"}, 64'(bus.busy), 64'd1);
    chk({tag, "_end0"}, 64'(bus.end_signal), 64'd0);
  endtask

  // Check the result at edge N+2 against the scoreboard
  task automatic check_result(input bit last, input string tag);
    chk({tag, "_busy2"}, 64'(bus.busy), 64'd0);
    chk({tag, "_end2"}, 64'(bus.end_signal), 64'(last));
    if (bus.end_signal === 1'b1) begin
      if (exp_q.size() > 0) begin
        chk({tag, "_y"}, bus.y_tmp, exp_q.pop_front());
      end else begin
        total++;
        fails++;
        $error("FAIL %s_sb_underflow observed=result expected=none", tag);
      end
    end
  endtask

  task automatic send_tile(input bit first, input bit last, input string tag);
    drive_tile(first, last, 1'b1, tag);
    @(posedge clk); #1;
    chk({tag, "_busy1"}, 64'(bus.busy), 64'd1);
    chk({tag, "_end1"}, 64'(bus.end_signal), 64'd0);
    @(posedge clk); #1;
    check_result(last, tag);
    @(posedge clk); #1;
    chk({tag, "_end3"}, 64'(bus.end_signal), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_tmp1    = '0;
    bus.m_tmp2    = '0;
    bus.m_tmp3    = '0;
    bus.m_tmp4    = '0;
    bus.acc_first = 1'b0;
    bus.acc_last  = 1'b0;
    for (int k = 0; k < 4; k++) macc[k] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_y", bus.y_tmp, 64'd0);
    chk("rst_end", 64'(bus.end_signal), 64'd0);
    chk("rst_drop", 64'(bus.drop_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single tile of 256s
    set_all(32'sd256);
    send_tile(1'b1, 1'b1, "t256");

    // Same tile accumulated over two channels
    send_tile(1'b1, 1'b0, "acc_a");
    send_tile(1'b0, 1'b1, "acc_b");

    // Largest positive inputs: wrap or saturate on narrowing
    set_all(32'sh7FFF_FFFF);
    send_tile(1'b1, 1'b1, "tmax");

    // Tile arriving one cycle after an accepted one is dropped
    set_all(32'sd256);
    drive_tile(1'b1, 1'b1, 1'b1, "drop");
    bus.m_tmp1    = {4{32'h7FFF_FFFF}};
    bus.acc_first = 1'b1;
    bus.acc_last  = 1'b1;
    bus.m_valid   = 1'b1;
    @(posedge clk); #1;
    bus.m_valid = 1'b0;
    chk("drop_busy1", 64'(bus.busy), 64'd1);
    chk("drop_err_set", 64'(bus.drop_err), 64'd1);
    @(posedge clk); #1;
    check_result(1'b1, "drop");
    @(posedge clk); #1;
    chk("drop_no_start", 64'(bus.busy), 64'd0);
    chk("drop_end3", 64'(bus.end_signal), 64'd0);
    chk("drop_err_sticky", 64'(bus.drop_err), 64'd1);

    // Reset during ROW after a partial sum has been accumulated
    send_tile(1'b1, 1'b0, "pre_rst");
    drive_tile(1'b0, 1'b1, 1'b0, "mid_rst");
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_y", bus.y_tmp, 64'd0);
    chk("mrst_drop", 64'(bus.drop_err), 64'd0);
    chk("mrst_end", 64'(bus.end_signal), 64'd0);
    for (int k = 0; k < 4; k++) macc[k] = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mrst_quiet%0d", i), 64'(bus.end_signal), 64'd0);
    end

    // acc_first=0 after reset adds onto the cleared accumulator
    send_tile(1'b0, 1'b1, "nofirst");

    // Single negative element: sign handling and packing order
    set_all(32'sd0);
    mm[0][0] = -32'sd512;
    send_tile(1'b1, 1'b1, "neg");

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
